dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 58 +++++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states, defaults and
// byte-lane helpers.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int unsigned DefDepthWords = 256;
  localparam int unsigned DefWaitCycles = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic logic [1:0] norm_size(logic [1:0] size);
    return (size == SIZE_B || size == SIZE_H) ? size : SIZE_W;
  endfunction

  function automatic logic [1:0] align_off(logic [1:0] size, logic [1:0] off);
    case (size)
      SIZE_B:  return off;
      SIZE_H:  return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_en(logic [1:0] size, logic [1:0] off);
    case (size)
      SIZE_B:  return 4'b0001 << off;
      SIZE_H:  return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(logic [1:0] size, logic [31:0] wdata);
    case (size)
      SIZE_B:  return {4{wdata[7:0]}};
      SIZE_H:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(logic [31:0] word, logic [1:0] size, logic [1:0] off,
                                           logic is_unsigned);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SIZE_B:  return is_unsigned ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SIZE_H:  return is_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with byte-enabled synchronous write and combinational read.
// Contents are never reset.
module dmem_array import dmem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = DefDepthWords,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed access latency.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses with rsp_err.
module dmem_responder import dmem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = DefDepthWords,
  parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, uns_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          accept, do_access, mem_we, err_now;
  logic          cur_we, cur_uns;
  logic [1:0]    cur_size, off;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata, mem_rdata, mem_wdata;
  logic [3:0]    mem_be;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  // A zero-wait access happens on the accepting edge, so it must use the live request fields.
  assign cur_we    = req_ready ? req_we : we_q;
  assign cur_uns   = req_ready ? req_unsigned : uns_q;
  assign cur_addr  = req_ready ? req_addr[AW+1:0] : addr_q;
  assign cur_wdata = req_ready ? req_wdata : wdata_q;
  assign cur_size  = norm_size(req_ready ? req_size : size_q);
  assign off       = align_off(cur_size, cur_addr[1:0]);

`ifdef DMEM_ALIGN_CHECK_EN
  assign err_now = (cur_size == SIZE_H && cur_addr[0]) ||
                   (cur_size == SIZE_W && cur_addr[1:0] != 2'b00);
`else
  assign err_now = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_access = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = StResp;
          end else begin
            cnt_d   = WaitInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset gates the write so a store caught by reset is never committed.
  assign mem_we    = do_access && cur_we && !err_now && !reset;
  assign mem_be    = lane_en(cur_size, off);
  assign mem_wdata = store_data(cur_size, cur_wdata);

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (do_access) begin
      err_d   = err_now;
      rdata_d = (cur_we || err_now) ? 32'h0 : load_ext(mem_rdata, cur_size, off, cur_uns);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      addr_q  <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (mem_be),
    .addr (cur_addr[AW+1:2]),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model.
// Honours DMEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_dmem_responder;

  localparam int unsigned Depth   = 256;
  localparam int unsigned WaitCyc = 2;
  localparam int unsigned Bytes   = Depth * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;
  logic [7:0] mdl [Bytes];

  dmem_responder #(
    .DEPTH_WORDS(Depth),
    .WAIT_CYCLES(WaitCyc)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory viewed as bytes: an access touches n consecutive bytes, little-endian.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns,
                                output logic [31:0] rd, output logic er);
    int n, base;
    logic [31:0] v;
    n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    base = int'(addr % Bytes);
    rd   = 32'h0;
    er   = 1'b0;
    if (base % n != 0) begin
`ifdef DMEM_ALIGN_CHECK_EN
      er = 1'b1;
      return;
`else
      base = base - base % n;
`endif
    end
    if (we) begin
      for (int i = 0; i < n; i++) mdl[base+i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[base+i];
      if (n < 4 && !uns && v[8*n-1]) begin
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      rd = v;
    end
  endfunction

  // Entered and left at 1 time unit after a rising edge.
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                      input int hold, output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] held;
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check_eq({tag, ":accept"}, 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    // A second request stays pending; it must not be taken before the handshake.
    req_we = 1'b0; req_addr = addr ^ 32'h4;
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    check_eq({tag, ":latency"}, n, WaitCyc);
    held = rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_eq({tag, ":hold_state"}, 32'({req_ready, rsp_valid}), 32'b01);
      check_eq({tag, ":hold_data"}, rsp_rdata, held);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq({tag, ":after_hs"}, 32'({req_ready, rsp_valid}), 32'b10);
  endtask

  task automatic run(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input int hold, output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic eer;
    model(we, addr, wdata, size, uns, erd, eer);
    xfer(tag, we, addr, wdata, size, uns, hold, rd, er);
    check_eq({tag, ":rdata"}, rd, erd);
    check_eq({tag, ":err"}, 32'(er), 32'(eer));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, upper;
    logic        er;
    logic [3:0]  idx;
    logic [1:0]  off;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b10; req_unsigned = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    check_eq("rst_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);

    // Give every word of the test window known contents.
    for (int w = 0; w < 16; w++) run("init", 1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0, 0, rd, er);

    run("st_w", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, rd, er);
    check_eq("st_w_zero", rd, 32'h0);
    run("ld_w", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
    check_eq("ld_w_val", rd, 32'hDEADBEEF);

    run("st_b", 1'b1, 32'h13, 32'h80, 2'b00, 1'b0, 0, rd, er);
    run("ld_bs", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 4, rd, er);
    check_eq("ld_bs_val", rd, 32'hFFFFFF80);
    run("ld_bu", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, rd, er);
    check_eq("ld_bu_val", rd, 32'h00000080);
    run("ld_w2", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, er);
    check_eq("ld_w2_val", rd, 32'h80ADBEEF);

    run("st_wrap", 1'b1, 32'h400, 32'h12345678, 2'b10, 1'b0, 0, rd, er);
    run("ld_wrap", 1'b0, 32'h000, 32'h0, 2'b10, 1'b0, 0, rd, er);
    check_eq("ld_wrap_val", rd, 32'h12345678);

    run("st_20", 1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 0, rd, er);
    run("st_mis", 1'b1, 32'h21, 32'h0000CAFE, 2'b01, 1'b0, 0, rd, er);
    run("ld_20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    check_eq("mis_word", rd, 32'h11223344);
`else
    check_eq("mis_word", rd, 32'h1122CAFE);
`endif

    // Reset in the middle of a store's wait must drop it.
    run("st_30", 1'b1, 32'h30, 32'h55AA55AA, 2'b10, 1'b0, 0, rd, er);
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h0BADF00D; req_size = 2'b10;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_mid_ready", 32'(req_ready), 32'd1);
    run("ld_30", 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 0, rd, er);
    check_eq("ld_30_val", rd, 32'h55AA55AA);

    for (int t = 0; t < 200; t++) begin
      idx   = 4'($urandom_range(0, 15));
      off   = 2'($urandom_range(0, 3));
      upper = $urandom;
      run("rand", 1'($urandom_range(0, 1)), {upper[31:10], 4'b0000, idx, off}, $urandom,
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2), rd, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
